dmem_responder: RTL and testbench

Data-memory responder for the MIPS datapath: the target end of the load/store interface that the core drives (address, write data, read/write strobes). It accepts one request at a time over a valid/ready handshake. It inserts a configurable number of wait states, commits writes with byte enables, and returns read data and an error flag on a single-cycle response pulse. It replaces the zero-latency data memory when the team moves to a multi-cycle core.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Multi-cycle data-memory responder for the MIPS load/store interface
//
// Accepts one load/store at a time over a valid/ready handshake, waits
// WAIT_STATES cycles, commits the access and returns a one-cycle response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (reject addr[1:0] != 0).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_wdata, req_be   store data and byte-lane enables
//   rsp_valid           one-cycle response pulse
//   rsp_rdata, rsp_err  load data / reject flag, valid with rsp_valid
//   busy                high in WAIT and RESP

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  count;

  // Request captured at accept; the low address bits are kept only as a
  // misalignment flag since the word index never uses them.
  logic        lat_write;
  logic [29:0] lat_word;
  logic        lat_misalign;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH_WORDS];

  // The access is committed on the edge entering RESP. With zero wait
  // states that is the accept edge itself, so the live request is used
  // directly instead of the (not yet loaded) latched copy.
  logic        in_idle;
  logic        acc_write;
  logic [29:0] acc_word;
  logic        acc_misalign;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [AW-1:0] acc_idx;
  logic        acc_err;
  logic        go_resp;

  assign in_idle      = (state == S_IDLE);
  assign acc_write    = in_idle ? req_write       : lat_write;
  assign acc_word     = in_idle ? req_addr[31:2]  : lat_word;
  assign acc_misalign = in_idle ? |req_addr[1:0]  : lat_misalign;
  assign acc_wdata    = in_idle ? req_wdata       : lat_wdata;
  assign acc_be       = in_idle ? req_be          : lat_be;
  assign acc_idx      = acc_word[AW-1:0];
  assign acc_err      = ({2'b00, acc_word} >= 32'(DEPTH_WORDS))
                      | (ALIGN_CHECK & acc_misalign);

  assign go_resp = (in_idle && req_valid && (WAIT_STATES == 0))
                 || ((state == S_WAIT) && (count == 4'd0));

  assign req_ready = in_idle && !reset;
  assign busy      = !in_idle;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_word     <= req_addr[31:2];
            lat_misalign <= |req_addr[1:0];
            lat_wdata    <= req_wdata;
            lat_be       <= req_be;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              count <= 4'(WAIT_STATES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state <= S_RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (go_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Memory has no reset; a reset edge suppresses the commit.
  always_ff @(posedge clock) begin
    if (!reset && go_resp && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Randomized self-checking bench for dmem_responder

module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS_A  = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rsp_rdata;
  logic [3:0]  a_be;

  logic        b_valid, b_ready, b_write, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rsp_rdata;
  logic [3:0]  b_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
    .clock(clk), .reset(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
    .clock(clk), .reset(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference memory for DUT A, all zeros at start.
  logic [31:0] model_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction on DUT A, entered and left at a negedge.
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input string tag);
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          seen;
    int          w;
    exp_err = (addr / 4 >= DEPTH) || (ALIGN && (addr % 4 != 0));
    exp_rd  = 32'd0;
    if (!exp_err) begin
      w = int'(addr / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[w] = (model_mem[w] & ~(32'hFF << (8*i)))
                                  | (wdata & (32'hFF << (8*i)));
      end else begin
        exp_rd = model_mem[w];
      end
    end
    check_eq({tag, ":ready"}, 32'(a_ready), 32'd1);
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    @(posedge clk); #1;
    // Post-accept request values must have no effect.
    a_valid = 1'b0; a_write = 1'($urandom); a_addr = $urandom;
    a_wdata = $urandom; a_be = 4'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        seen = 1'b1;
        check_eq({tag, ":latency"}, 32'(k), 32'(WS_A));
        check_eq({tag, ":err"}, 32'(a_rsp_err), 32'(exp_err));
        check_eq({tag, ":rdata"}, a_rsp_rdata, exp_rd);
      end else begin
        check_eq({tag, ":busy"}, 32'(a_busy), 32'd1);
      end
    end
    if (!seen) check_eq({tag, ":timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check_eq({tag, ":pulse_end"}, 32'(a_rsp_valid), 32'd0);
    check_eq({tag, ":ready_back"}, 32'(a_ready), 32'd1);
  endtask

  initial begin
    int  last_acc;
    int  accepts;
    int  pulses;
    bit  rsp_seen;
    bit  addr_ok;
    logic [31:0] ra;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h10; a_wdata = 32'h5555_5555; a_be = 4'hF;
    b_valid = 1'b0; b_write = 1'b0; b_addr = 32'h0;  b_wdata = 32'h0;          b_be = 4'h0;

    // Reset with a request pending: reset wins.
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("rst:ready_low", 32'(a_ready), 32'd0);
    check_eq("rst:busy", 32'(a_busy), 32'd0);
    check_eq("rst:rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rst:rdata", a_rsp_rdata, 32'd0);
    check_eq("rst:err", 32'(a_rsp_err), 32'd0);
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    check_eq("rst:ready_high", 32'(a_ready), 32'd1);
    check_eq("rst:idle", 32'(a_busy), 32'd0);

    // Directed scenarios.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
    xact(1'b0, 32'h10, 32'h0, 4'h0, "ld10");
    check_eq("ld10:value", a_rsp_rdata, 32'hDEADBEEF);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, "st20a");
    xact(1'b1, 32'h20, 32'h11223344, 4'b0101, "st20b");
    xact(1'b0, 32'h20, 32'h0, 4'h0, "ld20");
    check_eq("ld20:value", a_rsp_rdata, 32'hAA22CC44);
    xact(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, "st400");
    xact(1'b0, 32'h0, 32'h0, 4'h0, "ld0");
    check_eq("ld0:value", a_rsp_rdata, 32'd0);
    xact(1'b1, 32'h24, 32'h0BADF00D, 4'h0, "st24_be0");
    xact(1'b0, 32'h24, 32'h0, 4'h0, "ld24");
    xact(1'b1, 32'h10, 32'h12345678, 4'hF, "st10b");
    xact(1'b0, 32'h12, 32'h0, 4'h0, "ld12");
    check_eq("ld12:value", a_rsp_rdata, ALIGN ? 32'd0 : 32'h12345678);

    // Reset one cycle after accepting a store: aborted, nothing written.
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h30; a_wdata = 32'hFFFFFFFF; a_be = 4'hF;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rsp_seen = 1'b0;
    @(negedge clk);
    rsp_seen = rsp_seen | a_rsp_valid;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rsp_seen = rsp_seen | a_rsp_valid;
    end
    check_eq("abort:no_rsp", 32'(rsp_seen), 32'd0);
    xact(1'b0, 32'h30, 32'h0, 4'h0, "ld30");
    check_eq("ld30:value", a_rsp_rdata, 32'd0);

    // Randomized traffic, partly out of range and misaligned.
    for (int n = 0; n < 60; n++) begin
      ra = 32'($urandom_range(0, 1279));
      if (($urandom % 8) == 0) ra = $urandom;
      if (($urandom % 4) != 0) ra = ra & 32'hFFFF_FFFC;
      xact(1'($urandom), ra, $urandom, 4'($urandom), "rnd");
    end

    // Back-to-back handshake on the zero-wait instance.
    b_valid = 1'b1;
    last_acc = -1; accepts = 0; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("hs:ready_vs_busy", 32'(b_ready), 32'(!b_busy));
      if (b_rsp_valid) begin
        pulses++;
        check_eq("hs:rsp_after_accept", 32'(c - last_acc), 32'd1);
        check_eq("hs:rdata", b_rsp_rdata, 32'd0);
      end
      if (b_ready) begin
        if (last_acc >= 0) check_eq("hs:interval", 32'(c - last_acc), 32'd2);
        last_acc = c;
        accepts++;
      end
    end
    b_valid = 1'b0;
    @(negedge clk);
    if (b_rsp_valid) pulses++;
    check_eq("hs:accepts", 32'(accepts), 32'd10);
    check_eq("hs:pulses", 32'(pulses), 32'(accepts));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
